// File: rtl/message_gen_seq.sv
// message_gen_seq: self-sequencing spread-spectrum message generator with double-buffered
// per-channel messages and runtime lane routing. Define MSG_GEN_LANE_SUM_EN for mask/sum lanes.
module message_gen_seq #(
  parameter int NUM_CH        = 8,
  parameter int NUM_LANES     = 4,
  parameter int PCODE_LEN     = 40920,
  parameter int PCODE_REPEATS = 10,
  parameter int MESSAGE_LEN   = 120,
  parameter int DATA_W        = 12,
  localparam int ADDR_W = (PCODE_LEN > 1) ? $clog2(PCODE_LEN) : 1,
  localparam int REP_W  = (PCODE_REPEATS > 1) ? $clog2(PCODE_REPEATS) : 1,
  localparam int BIT_W  = (MESSAGE_LEN > 1) ? $clog2(MESSAGE_LEN) : 1,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WORDS  = (MESSAGE_LEN + 31) / 32,
  localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1,
`ifdef MSG_GEN_LANE_SUM_EN
  localparam int SEL_W  = NUM_CH
`else
  localparam int SEL_W  = CH_W
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        stop,
  input  logic                        sys_time_sync_done,
  input  logic                        dac_valid,
  input  logic [DATA_W-1:0]           pcode_hval,
  input  logic [DATA_W-1:0]           pcode_lval,
  output logic [ADDR_W-1:0]           pcode_addr,
  input  logic [NUM_CH-1:0]           pcode_chip,
  input  logic [NUM_CH-1:0]           channel_enable,
  input  logic                        msg_wr_en,
  input  logic [CH_W-1:0]             msg_wr_ch,
  input  logic [WORD_W-1:0]           msg_wr_word,
  input  logic [31:0]                 msg_wr_data,
  input  logic [NUM_CH-1:0]           msg_commit,
  output logic [NUM_CH-1:0]           commit_pending,
  input  logic [NUM_LANES*SEL_W-1:0]  lane_sel,
  output logic [NUM_LANES*DATA_W-1:0] lane_data,
  output logic                        lane_valid,
  output logic [BIT_W-1:0]            msg_bit_idx,
  output logic                        frame_done,
  output logic                        busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [ADDR_W-1:0]           chip_q, chip_d;
  logic [REP_W-1:0]            rep_q, rep_d;
  logic [BIT_W-1:0]            bit_q, bit_d;
  logic                        frame_done_q, frame_done_d;
  logic                        busy_q, busy_d;
  logic [NUM_CH-1:0]           active_q, active_d;
  logic [NUM_CH-1:0]           pend_q, pend_d;
  logic [NUM_CH-1:0]           swap_s;
  logic [MESSAGE_LEN-1:0]      mem_q [NUM_CH][2];
  logic [MESSAGE_LEN-1:0]      wr_mask_s, wr_bits_s;
  logic                        wr_ok_s;
  logic                        run_s, adv_s;
  logic                        s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic                        lane_valid_q, lane_valid_d;
  logic [NUM_CH-1:0]           msg_bit_q, msg_bit_d, sym_q, sym_d;
  logic [NUM_LANES*SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_LANES*DATA_W-1:0] lane_q, lane_d, lane_calc_s;
  logic signed [DATA_W-1:0]    sample_s [NUM_CH];

`ifdef MSG_GEN_LANE_SUM_EN
  localparam int SUM_W = DATA_W + CH_W + 1;
  localparam logic signed [SUM_W-1:0] SAT_MAX = (SUM_W'(1) <<< (DATA_W - 1)) - SUM_W'(1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  logic signed [SUM_W-1:0]     acc_s;
`else
  logic [CH_W-1:0]             idx_s;
`endif

  assign run_s = (state_q == ST_RUN);
  assign adv_s = run_s & dac_valid & ~stop;

  // stop overrides everything; ARMED waits on the sync level
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start) state_d = ST_ARMED; else state_d = ST_IDLE;
        ST_ARMED: if (sys_time_sync_done) state_d = ST_RUN; else state_d = ST_ARMED;
        ST_RUN:   state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // chip -> repeat -> bit counter chain, advancing once per accepted dac_valid
  always_comb begin
    chip_d       = chip_q;
    rep_d        = rep_q;
    bit_d        = bit_q;
    frame_done_d = 1'b0;
    if (stop) begin
      chip_d = '0;
      rep_d  = '0;
      bit_d  = '0;
    end else if (adv_s) begin
      if (chip_q == ADDR_W'(PCODE_LEN - 1)) begin
        chip_d = '0;
        if (rep_q == REP_W'(PCODE_REPEATS - 1)) begin
          rep_d = '0;
          if (bit_q == BIT_W'(MESSAGE_LEN - 1)) begin
            bit_d        = '0;
            frame_done_d = 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          rep_d = rep_q + 1'b1;
        end
      end else begin
        chip_d = chip_q + 1'b1;
      end
    end else begin
      chip_d = chip_q;
    end
  end

  // bank swap: at the frame boundary while running, otherwise one cycle after commit
  always_comb begin
    if (run_s) begin
      swap_s = (pend_q | msg_commit) & {NUM_CH{frame_done_q}};
    end else begin
      swap_s = pend_q;
    end
    pend_d   = (pend_q | msg_commit) & ~swap_s;
    active_d = active_q ^ swap_s;
  end

  // word write decode; bits past MESSAGE_LEN simply have no storage
  always_comb begin
    wr_ok_s = msg_wr_en & (int'(msg_wr_ch) < NUM_CH) & (int'(msg_wr_word) < WORDS);
    for (int i = 0; i < MESSAGE_LEN; i++) begin
      wr_mask_s[i] = ((i / 32) == int'(msg_wr_word));
      wr_bits_s[i] = msg_wr_data[i % 32];
    end
  end

  // cycle 0/1 pipeline inputs; reading through active_d lets a frame start on the new bank
  always_comb begin
    s1_valid_d   = adv_s;
    s2_valid_d   = s1_valid_q & ~stop;
    lane_valid_d = s2_valid_q & ~stop;
    for (int c = 0; c < NUM_CH; c++) begin
      msg_bit_d[c] = mem_q[c][active_d[c]][bit_q];
    end
    sym_d = pcode_chip ^ msg_bit_q;
    sel_d = lane_sel;
  end

  // cycle 2 per-channel sample with output gate
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (!channel_enable[c]) begin
        sample_s[c] = '0;
      end else if (sym_q[c]) begin
        sample_s[c] = pcode_lval;
      end else begin
        sample_s[c] = pcode_hval;
      end
    end
  end

  // cycle 2 lane routing
  always_comb begin
    lane_calc_s = '0;
`ifdef MSG_GEN_LANE_SUM_EN
    acc_s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      acc_s = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (sel_q[l*NUM_CH + c]) acc_s = acc_s + SUM_W'(sample_s[c]);
        else acc_s = acc_s;
      end
      if (acc_s > SAT_MAX) lane_calc_s[l*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
      else if (acc_s < SAT_MIN) lane_calc_s[l*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
      else lane_calc_s[l*DATA_W +: DATA_W] = acc_s[DATA_W-1:0];
    end
`else
    idx_s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      idx_s = sel_q[l*SEL_W +: SEL_W];
      if (int'(idx_s) < NUM_CH) lane_calc_s[l*DATA_W +: DATA_W] = sample_s[idx_s];
      else lane_calc_s[l*DATA_W +: DATA_W] = '0;
    end
`endif
    if (s2_valid_q) lane_d = lane_calc_s;
    else lane_d = lane_q;
  end

  // control, counter and pipeline registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      chip_q       <= '0;
      rep_q        <= '0;
      bit_q        <= '0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      active_q     <= '0;
      pend_q       <= '0;
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      lane_valid_q <= 1'b0;
      msg_bit_q    <= '0;
      sym_q        <= '0;
      sel_q        <= '0;
      lane_q       <= '0;
    end else begin
      state_q      <= state_d;
      chip_q       <= chip_d;
      rep_q        <= rep_d;
      bit_q        <= bit_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
      active_q     <= active_d;
      pend_q       <= pend_d;
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      lane_valid_q <= lane_valid_d;
      msg_bit_q    <= msg_bit_d;
      sym_q        <= sym_d;
      sel_q        <= sel_d;
      lane_q       <= lane_d;
    end
  end

  // message storage; writes go to the bank that is shadow before this cycle's swap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem_q[c][0] <= '0;
        mem_q[c][1] <= '0;
      end
    end else if (wr_ok_s) begin
      mem_q[msg_wr_ch][~active_q[msg_wr_ch]] <=
        (mem_q[msg_wr_ch][~active_q[msg_wr_ch]] & ~wr_mask_s) | (wr_bits_s & wr_mask_s);
    end
  end

  assign pcode_addr     = chip_q;
  assign msg_bit_idx    = bit_q;
  assign frame_done     = frame_done_q;
  assign busy           = busy_q;
  assign commit_pending = pend_q;
  assign lane_valid     = lane_valid_q;
  assign lane_data      = lane_q;

endmodule
